// File: rtl/shift_seq_if.sv
// Request/response bundle for shift_seq: operand, shift amount and op in,
// shifted result out, each side with its own valid/ready handshake.
interface shift_seq_if #(
  parameter int N = 32
) ();
  localparam int S = $clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [S-1:0] shamt;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y;

  modport master (
    output in_valid, a, shamt, op, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, shamt, op, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/shift_seq.sv
// Sequential barrel shifter: one log2 stage per clock, fixed S-cycle latency.
// Define SHIFT_SEQ_ROTATE_EN to make op=11 a rotate right; otherwise op=11 passes a through.
module shift_seq #(
  parameter int N = 32
) (
  input logic        clk,
  input logic        rst,
  shift_seq_if.slave bus
);
  localparam int S = $clog2(N);
`ifdef SHIFT_SEQ_ROTATE_EN
  localparam logic [S:0] N_W = (S+1)'(N);
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [S-1:0] k;
  logic [N-1:0] work;
  logic [N-1:0] work_nxt;
  logic [S-1:0] shamt_q;
  logic [1:0]   op_q;
  logic         sign_q;
  logic [S-1:0] amt;
  logic         accept;

  assign accept = (state == IDLE) && bus.in_valid;
  assign bus.y  = work;

  // Stage k moves the working value by 2^k only when bit k of the captured amount is set.
  always_comb begin
    amt      = S'(1) << k;
    work_nxt = work;
    if (shamt_q[k]) begin
      case (op_q)
        2'b00:   work_nxt = work << amt;
        2'b01:   work_nxt = work >> amt;
        2'b10:   work_nxt = (work >> amt) | (sign_q ? ~({N{1'b1}} >> amt) : '0);
        default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
          work_nxt = (work >> amt) | (work << (N_W - {1'b0, amt}));
`else
          work_nxt = work;
`endif
        end
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (k == S'(S - 1)) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operands are latched once at acceptance so later input changes cannot disturb the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= '0;
      work    <= '0;
      shamt_q <= '0;
      op_q    <= 2'b00;
      sign_q  <= 1'b0;
    end else if (accept) begin
      k       <= '0;
      work    <= bus.a;
      shamt_q <= bus.shamt;
      op_q    <= bus.op;
      sign_q  <= bus.a[N-1];
    end else if (state == SHIFT) begin
      work <= work_nxt;
      k    <= k + 1'b1;
    end
  end
endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed vector table, hand-written
// handshake/reset sequences, and randomized ops against an arithmetic model.
module tb_shift_seq;
  localparam int N = 32;
  localparam int S = 5;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  shift_seq_if #(.N(N)) bus ();

  shift_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] y;
  } vec_t;

  vec_t vecs [8];

  // Reference behaviour straight from the shift definitions, independent of any stage structure.
  function automatic logic [31:0] model(input logic [31:0] av, input int sh, input logic [1:0] o);
    case (o)
      2'b00:   return av << sh;
      2'b01:   return av >> sh;
      2'b10:   return 32'($signed(av) >>> sh);
      default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
        if (sh == 0) return av;
        return (av >> sh) | (av << (32 - sh));
`else
        return av;
`endif
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one request, scramble the inputs after the accept edge, and wait (bounded) for out_valid.
  task automatic applyStimulus(input logic [31:0] av, input logic [4:0] sh, input logic [1:0] o,
                               output int latency, output logic [31:0] yv);
    bus.in_valid  = 1'b1;
    bus.a         = av;
    bus.shamt     = sh;
    bus.op        = o;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.shamt    = 5'($urandom);
    bus.op       = 2'($urandom);
    latency      = 0;
    while (!bus.out_valid && latency < 20) begin
      tick();
      latency++;
    end
    yv = bus.y;
  endtask

  task automatic finishOp();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] yv;
    logic [31:0] y0;
    logic [31:0] exp_y;
    int          stale;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000};
    vecs[1] = '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000};
    vecs[2] = '{32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000};
    vecs[3] = '{32'h1234_5678, 5'd0,  2'b01, 32'h1234_5678};
`ifdef SHIFT_SEQ_ROTATE_EN
    vecs[4] = '{32'h0000_00F1, 5'd4,  2'b11, 32'h1000_000F};
`else
    vecs[4] = '{32'h0000_00F1, 5'd4,  2'b11, 32'h0000_00F1};
`endif
    vecs[5] = '{32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001};
    vecs[6] = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000};
    vecs[7] = '{32'hDEAD_BEEF, 5'd16, 2'b00, 32'hBEEF_0000};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.shamt     = '0;
    bus.op        = 2'b00;
    bus.out_ready = 1'b0;
    tick();
    tick();
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_y", bus.y, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].shamt, vecs[i].op, lat, yv);
      checkOutput($sformatf("vec%0d_y", i), yv, vecs[i].y);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(S));
      finishOp();
    end

    // Back-pressure: result and flags must hold while the consumer stalls.
    applyStimulus(32'hCAFE_F00D, 5'd9, 2'b01, lat, y0);
    checkOutput("bp_y", y0, 32'hCAFE_F00D >> 9);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_y_hold", bus.y, y0);
      checkOutput("bp_out_valid_hold", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    finishOp();
    checkOutput("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

    // in_valid held through SHIFT and the DONE handshake must not disturb or re-trigger.
    bus.in_valid = 1'b1;
    bus.a        = 32'h0000_000F;
    bus.shamt    = 5'd1;
    bus.op       = 2'b00;
    tick();
    bus.a     = 32'hFFFF_FFFF;
    bus.shamt = 5'd7;
    bus.op    = 2'b10;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("busy_ignore_y", bus.y, 32'h0000_001E);
    checkOutput("busy_ignore_latency", 32'(lat), 32'(S));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("no_accept_at_handshake", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    if (bus.out_valid || !bus.in_ready) finishOp();

    // Reset while k=2 aborts the operation with no later result.
    bus.in_valid = 1'b1;
    bus.a        = 32'h0000_0003;
    bus.shamt    = 5'd31;
    bus.op       = 2'b00;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_y", bus.y, 32'd0);
    checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst   = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) stale++;
    end
    checkOutput("abort_no_stale_pulse", 32'(stale), 32'd0);

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [4:0]  rs;
      logic [1:0]  ro;
      ra    = $urandom;
      rs    = 5'($urandom_range(0, 31));
      ro    = 2'($urandom_range(0, 3));
      exp_y = model(ra, int'(rs), ro);
      applyStimulus(ra, rs, ro, lat, yv);
      checkOutput($sformatf("rand%0d_op%0d_sh%0d_y", i, ro, rs), yv, exp_y);
      checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'(S));
      finishOp();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
